// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

    localparam int unsigned SA_DEFAULT_N = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Gate-level one-bit full adder cell, time-multiplexed by serial_adder_ctrl.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic axb;

    assign axb  = a ^ b;
    assign s    = axb ^ cin;
    assign cout = (a & b) | (cin & axb);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial N-bit adder: one full_adder reused over N cycles, LSB first.
// Define SERIAL_ADDER_OVERFLOW_EN to add the registered signed-overflow output o_overflow.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned N = SA_DEFAULT_N
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_carry_in,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_s,
    output logic         o_carry_out
`ifdef SERIAL_ADDER_OVERFLOW_EN
    ,
    output logic         o_overflow
`endif
);

    localparam int unsigned CW = $clog2(N);

    state_t        state;
    state_t        next_state;
    logic [N-1:0]  a_sr;
    logic [N-1:0]  b_sr;
    logic [N-1:0]  result;
    logic          carry;
    logic [CW-1:0] count;
    logic          last;
    logic          fa_s;
    logic          fa_cout;

    assign last = (count == CW'(N - 1));

    full_adder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        o_ready    = 1'b0;
        o_valid    = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) next_state = RUN;
            end
            RUN: begin
                if (last) next_state = DONE;
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Carry flop doubles as the carry-out once the last bit has been added.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            a_sr   <= '0;
            b_sr   <= '0;
            result <= '0;
            carry  <= 1'b0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        a_sr   <= i_a;
                        b_sr   <= i_b;
                        carry  <= i_carry_in;
                        result <= '0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    result <= {fa_s, result[N-1:1]};
                    a_sr   <= {1'b0, a_sr[N-1:1]};
                    b_sr   <= {1'b0, b_sr[N-1:1]};
                    carry  <= fa_cout;
                    count  <= count + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_s         = result;
    assign o_carry_out = carry;

`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic overflow;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            overflow <= 1'b0;
        end else if (state == RUN && last) begin
            overflow <= carry ^ fa_cout;
        end
    end

    assign o_overflow = overflow;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (N=8): timeline model plus directed literal checks.
module tb_serial_adder_ctrl;

    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_valid = 1'b0;
    logic         o_ready;
    logic [N-1:0] i_a = '0;
    logic [N-1:0] i_b = '0;
    logic         i_carry_in = 1'b0;
    logic         o_valid;
    logic         i_ready = 1'b0;
    logic [N-1:0] o_s;
    logic         o_carry_out;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic         o_overflow;
`endif

    int checks   = 0;
    int failures = 0;

    serial_adder_ctrl #(.N(N)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_a         (i_a),
        .i_b         (i_b),
        .i_carry_in  (i_carry_in),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_s         (o_s),
        .o_carry_out (o_carry_out)
`ifdef SERIAL_ADDER_OVERFLOW_EN
        ,
        .o_overflow  (o_overflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted operation yields a+b+cin exactly N edges later and is
    // held until the consumer takes it; the block is busy from accept to handshake.
    int           cyc = 0;
    logic         m_ready = 1'b1;
    logic         m_valid = 1'b0;
    int           m_left = 0;
    logic [N:0]   m_sum = '0;
    logic         m_ovf = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready = 1'b1;
            m_valid = 1'b0;
            m_left  = 0;
            m_sum   = '0;
            m_ovf   = 1'b0;
        end else begin
            cyc++;
            if (m_ready) begin
                if (i_valid) begin
                    m_ready = 1'b0;
                    m_left  = N;
                    m_sum   = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_carry_in};
                    m_ovf   = (i_a[N-1] == i_b[N-1]) && (m_sum[N-1] != i_a[N-1]);
                end
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_valid = 1'b1;
            end else if (i_ready) begin
                m_valid = 1'b0;
                m_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        chk("ready", 32'(o_ready), 32'(m_ready));
        chk("valid", 32'(o_valid), 32'(m_valid));
        if (m_valid || rst) begin
            chk("sum", 32'(o_s), 32'(m_sum[N-1:0]));
            chk("carry_out", 32'(o_carry_out), 32'(m_sum[N]));
`ifdef SERIAL_ADDER_OVERFLOW_EN
            chk("overflow", 32'(o_overflow), 32'(m_ovf));
`endif
        end
    end

    int acc_q[$];

    always @(negedge clk) begin
        if (!rst && o_ready && i_valid) acc_q.push_back(cyc);
    end

    task automatic wait_ready();
        int k = 0;
        while (!o_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        chk("ready_wait", 32'(o_ready), 32'd1);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic [7:0] es, input logic ec, input logic eo,
                          input int hold, input bit isolate);
        int k;
        wait_ready();
        i_a = a; i_b = b; i_carry_in = cin;
        i_valid = 1'b1; i_ready = 1'b0;
        @(posedge clk); #1;
        i_valid = 1'b0;
        if (isolate) begin
            i_a = '1; i_b = '1; i_carry_in = 1'b1;
        end
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!o_valid && k < 40);
        chk("latency", 32'(k), 32'd8);
        chk("sum_lit", 32'(o_s), 32'(es));
        chk("cout_lit", 32'(o_carry_out), 32'(ec));
`ifdef SERIAL_ADDER_OVERFLOW_EN
        chk("ovf_lit", 32'(o_overflow), 32'(eo));
`else
        if (eo !== 1'bx) begin end
`endif
        for (int h = 0; h < hold; h++) begin
            i_valid = (h % 2 == 0);
            i_a = 8'hA5; i_b = 8'h5A;
            @(posedge clk); #1;
            chk("hold_valid", 32'(o_valid), 32'd1);
            chk("hold_ready", 32'(o_ready), 32'd0);
            chk("hold_sum", 32'(o_s), 32'(es));
            chk("hold_cout", 32'(o_carry_out), 32'(ec));
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        chk("ready_after", 32'(o_ready), 32'd1);
        chk("valid_after", 32'(o_valid), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 32'(o_ready), 32'd1);
        chk("reset_valid", 32'(o_valid), 32'd0);
        chk("reset_sum", 32'(o_s), 32'd0);
        rst = 1'b0;

        run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 0, 1'b0);
        run_op(8'hC3, 8'h81, 1'b1, 8'h45, 1'b1, 1'b1, 5, 1'b0);
        run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 0, 1'b1);

        // Reset three cycles into RUN
        wait_ready();
        i_a = 8'h55; i_b = 8'h11; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(o_ready), 32'd1);
        chk("midrst_valid", 32'(o_valid), 32'd0);
        chk("midrst_sum", 32'(o_s), 32'd0);
        chk("midrst_cout", 32'(o_carry_out), 32'd0);
`ifdef SERIAL_ADDER_OVERFLOW_EN
        chk("midrst_ovf", 32'(o_overflow), 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 0, 1'b0);

        // Back-to-back with both handshakes held high
        wait_ready();
        acc_q.delete();
        i_a = 8'h10; i_b = 8'h20; i_carry_in = 1'b0;
        i_valid = 1'b1; i_ready = 1'b1;
        for (int k = 0; k < 60 && acc_q.size() < 2; k++) begin
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        chk("b2b_count", 32'(acc_q.size()), 32'd2);
        if (acc_q.size() >= 2) chk("b2b_interval", 32'(acc_q[1] - acc_q[0]), 32'd10);
        wait_ready();
        i_ready = 1'b0;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial N-bit adder controller. Accepts two N-bit operands and a carry-in over a valid/ready handshake. It time-multiplexes a single gate-level `full_adder` cell over N cycles, LSB first, keeping the carry in a flip-flop between cycles. It then presents the N-bit sum and carry-out over a second valid/ready handshake. It serves as the area-minimal alternative to the ripple-carry adder in the arithmetic datapath.

## Interface
Parameters:
- `N`, default 8: operand width; legal range N ≥ 2.

Ports:
- `i_clk`, input, 1: single clock; all state updates on the rising edge.
- `i_reset`, input, 1: asynchronous, active-high reset.
- `i_valid`, input, 1: operands are valid.
- `o_ready`, output, 1: block accepts operands.
- `i_a`, input, N: operand A.
- `i_b`, input, N: operand B.
- `i_carry_in`, input, 1: carry into bit 0.
- `o_valid`, output, 1: result is valid.
- `i_ready`, input, 1: consumer accepts the result.
- `o_s`, output, N: sum.
- `o_carry_out`, output, 1: carry out of bit N-1.
- `o_overflow`, output, 1: signed overflow. Present only with `SERIAL_ADDER_OVERFLOW_EN`.

## Operation
The block is a state machine with states IDLE, RUN and DONE.

- **IDLE**
  - `o_ready=1`, `o_valid=0`.
  - On `i_valid` at a rising edge, latch `i_a`/`i_b` into shift registers A and B, load the carry flop from `i_carry_in`, clear the bit counter and the result register, and go to RUN.
- **RUN**
  - `o_ready=0`, `o_valid=0`.
  - Each cycle, the `full_adder` computes from A[0], B[0] and carry.
  - The sum bit shifts into result[N-1] and the result shifts right.
  - A and B shift right, the carry flop takes the carry-out, and the counter increments.
  - When the counter reaches N-1, that cycle's update completes and the state goes to DONE.
- **DONE**
  - `o_valid=1`; `o_s`, `o_carry_out` (and `o_overflow`) are held stable.
  - On `i_ready`, go to IDLE.
  - `i_valid` is ignored in DONE because `o_ready=0`.
- **Arithmetic**
  - The result is the unsigned sum {carry_out, s} = a + b + carry_in, which is exact in N+1 bits.
  - The counter is $clog2(N) bits wide. It never wraps inside an operation.
- **Operand isolation**
  - Input operands are sampled only at the accept edge.
  - Changes on `i_a`, `i_b` or `i_carry_in` during RUN or DONE have no effect.
- **Reset**
  - Asserting `i_reset` at any time, including mid-RUN, forces IDLE immediately.
  - All registers clear: result 0, carry 0, counter 0.
  - Outputs during reset are `o_ready=1`, `o_valid=0`, `o_s=0`, `o_carry_out=0`, `o_overflow=0`.
  - The aborted operation produces no result.

## Timing
- Accept edge T: both `i_valid` and `o_ready` are high.
- RUN occupies the N cycles following T.
- `o_valid` rises after edge T+N, giving a latency of N cycles from accept to result valid.
- The result handshake completes at the first edge with `o_valid & i_ready`. `o_ready` rises in the next cycle.
- Minimum issue interval is N+2 cycles: IDLE 1, RUN N, DONE 1.
- Outputs are registered. There is no combinational path from any input to any output, except that `o_ready` and `o_valid` are decoded from state only.

## Configuration
`SERIAL_ADDER_OVERFLOW_EN` controls the signed-overflow output.

- **Defined:**
  - Adds the `o_overflow` port and one flop.
  - In the final RUN cycle (counter = N-1), the flop captures carry-into-MSB XOR carry-out-of-MSB.
  - Its value is valid with `o_valid`, holds through DONE, and is reset to 0.
- **Undefined:**
  - Neither the port nor the flop exists.
  - All other behaviour is identical.

## Structure
- **`serial_adder_pkg`** holds:
  - the state typedef enum {IDLE, RUN, DONE};
  - the default-width constant of 8.
- **Sub-module:** one instance of the existing gate-level `full_adder`, driven by A[0], B[0] and the carry flop.
- **Controller logic:** shift registers, counter and state machine all live in `serial_adder_ctrl`. No further sub-modules.

## Test plan
All scenarios use N=8.

1. **Signed overflow case:** a=0x5A, b=0x3C, cin=0.
   - Expect o_s=0x96 and carry_out=0.
   - With the macro defined, expect overflow=1.
   - `o_valid` rises exactly 8 cycles after the accept edge.
2. **Carry wrap-around:** a=0xFF, b=0x01, cin=0.
   - Expect o_s=0x00, carry_out=1, overflow=0.
   - Repeat with a=0xFF, b=0x00, cin=1: expect o_s=0x00, carry_out=1.
3. **Backpressure:** hold `i_ready`=0 for 5 cycles in DONE.
   - `o_s`, `o_carry_out` and `o_valid` stay stable.
   - `o_ready` stays 0 and `i_valid` pulses are ignored.
   - After `i_ready`, `o_ready`=1 on the next cycle.
4. **Operand isolation:** accept a=0x12, b=0x34, then drive a=0xFF, b=0xFF during RUN.
   - Result is still 0x46, carry_out=0.
5. **Reset mid-operation:** assert `i_reset` asynchronously 3 cycles into RUN.
   - All outputs go to their reset values immediately.
   - After release, a=0x01, b=0x01 yields 0x02 normally.
6. **Back-to-back operations:** issue two operations with `i_valid` held high and `i_ready` held high.
   - The second accept occurs exactly 10 cycles after the first.
